// File: rtl/sub_result_decoder.sv
// Sign-magnitude decoder for the 8-bit subtractor result, buffered in a
// small FIFO. Optional statistics counters are enabled by SUB_DEC_STATS_EN.
module sub_result_decoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_diff,
    input  logic        in_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_mag,
    output logic        out_neg,
    output logic        out_zero,
    output logic        out_err
`ifdef SUB_DEC_STATS_EN
    ,
    output logic [7:0]  neg_count,
    output logic [15:0] beat_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0] mag;
        logic       neg;
        logic       zero;
        logic       err;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        dec;
    entry_t        head_next;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_after_pop;
    logic          acc;
    logic          pop;

    assign in_ready = (count < CW'(DEPTH)) && !rst;
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Decode the raw subtractor beat into sign-magnitude form.
    always_comb begin
        dec = '0;
        if (in_cout) begin
            dec.mag = in_diff;
        end else if (in_diff == 8'h00) begin
            dec.err = 1'b1;
        end else begin
            dec.mag = ~in_diff + 8'd1;
            dec.neg = 1'b1;
        end
        dec.zero = (dec.mag == 8'h00);
    end

    // Next occupancy and the entry that will sit at the head.
    always_comb begin
        count_next      = count;
        rd_next         = rd_ptr;
        count_after_pop = count;
        if (pop) begin
            rd_next         = rd_ptr + PW'(1);
            count_after_pop = count - CW'(1);
        end
        unique case ({acc, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        if (acc && (count_after_pop == '0)) begin
            head_next = dec;
        end else begin
            head_next = mem[rd_next];
        end
    end

    // Buffer storage; contents need no reset since occupancy gates them.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Pointers, occupancy and registered head-of-queue outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_mag   <= 8'h00;
            out_neg   <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (count_next != '0) begin
                out_mag  <= head_next.mag;
                out_neg  <= head_next.neg;
                out_zero <= head_next.zero;
                out_err  <= head_next.err;
            end
        end
    end

`ifdef SUB_DEC_STATS_EN
    // Saturating negative-beat counter and wrapping total-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_count  <= 8'h00;
            beat_count <= 16'h0000;
        end else if (acc) begin
            beat_count <= beat_count + 16'd1;
            if (dec.neg && (neg_count != 8'hFF)) begin
                neg_count <= neg_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sub_result_decoder.sv
// Directed and streaming checks for sub_result_decoder (DEPTH=2).
// Stats checks are built only when SUB_DEC_STATS_EN is defined.
module tb_sub_result_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_diff;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_mag;
    logic        out_neg;
    logic        out_zero;
    logic        out_err;
`ifdef SUB_DEC_STATS_EN
    logic [7:0]  neg_count;
    logic [15:0] beat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sub_result_decoder #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_diff    (in_diff),
        .in_cout    (in_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mag    (out_mag),
        .out_neg    (out_neg),
        .out_zero   (out_zero),
        .out_err    (out_err)
`ifdef SUB_DEC_STATS_EN
        ,
        .neg_count  (neg_count),
        .beat_count (beat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        in_valid = 1'b0;
        in_diff = 8'h00;
        in_cout = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        got = {out_valid, out_mag, out_neg, out_zero, out_err};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", got, 12'h000);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_decode();
        logic [7:0]  vd [5];
        logic        vc [5];
        logic [11:0] ve [5];
        logic [11:0] got;
        vd[0] = 8'h05; vc[0] = 1'b1; ve[0] = {1'b1, 8'h05, 3'b000};
        vd[1] = 8'hFB; vc[1] = 1'b0; ve[1] = {1'b1, 8'h05, 3'b100};
        vd[2] = 8'h80; vc[2] = 1'b0; ve[2] = {1'b1, 8'h80, 3'b100};
        vd[3] = 8'h00; vc[3] = 1'b1; ve[3] = {1'b1, 8'h00, 3'b010};
        vd[4] = 8'h00; vc[4] = 1'b0; ve[4] = {1'b1, 8'h00, 3'b011};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_diff = vd[i];
            in_cout = vc[i];
            step();
            in_valid = 1'b0;
            got = {out_valid, out_mag, out_neg, out_zero, out_err};
            n_checks++;
            if (got !== ve[i]) begin
                n_fail++;
                $display("FAIL decode_%0d got=%h exp=%h", i, got, ve[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] got;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_cout = 1'b1;
        in_diff = 8'h11;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_after1 got=%b exp=1", in_ready);
        end
        in_diff = 8'h22;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_after2 got=%b exp=0", in_ready);
        end
        in_diff = 8'h33;
        step();
        step();
        got = {out_valid, out_mag, in_ready};
        n_checks++;
        if (got !== {1'b1, 8'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold got=%h exp=%h", got, {1'b1, 8'h11, 1'b0});
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_ready got=%b exp=0", in_ready);
        end
        step();
        got = {out_valid, out_mag, in_ready};
        n_checks++;
        if (got !== {1'b1, 8'h22, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_second got=%h exp=%h", got, {1'b1, 8'h22, 1'b1});
        end
        step();
        in_valid = 1'b0;
        got = {out_valid, out_mag, 1'b0};
        n_checks++;
        if (got !== {1'b1, 8'h33, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_third got=%h exp=%h", got, {1'b1, 8'h33, 1'b0});
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_push_pop_one();
        logic [9:0] got;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_cout = 1'b1;
        in_diff = 8'h44;
        step();
        in_diff = 8'h55;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        got = {out_valid, out_mag, in_ready};
        n_checks++;
        if (got !== {1'b1, 8'h55, 1'b1}) begin
            n_fail++;
            $display("FAIL push_pop got=%h exp=%h", got, {1'b1, 8'h55, 1'b1});
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        logic        stale;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_cout = 1'b0;
        in_diff = 8'hF0;
        step();
        step();
        rst = 1'b1;
        in_diff = 8'hE0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_ready got=%b exp=0", in_ready);
        end
        step();
        got = {out_valid, out_mag, out_neg, out_zero, out_err};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%h exp=%h", got, 12'h000);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            stale = stale | out_valid;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stale got=%b exp=0", stale);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0]  qm [$];
        logic        qn [$];
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  em;
        logic        en;
        logic [10:0] got;
        logic [10:0] exp_v;
        int          acc_n;
        int          cyc;
        do_reset();
        acc_n = 0;
        cyc = 0;
        while ((acc_n < 10000 || qm.size() != 0) && cyc < 60000) begin
            if (acc_n < 10000) begin
                a = 8'($urandom);
                b = 8'($urandom);
                in_valid = ($urandom_range(3) != 0);
                in_diff = a - b;
                in_cout = (a >= b);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (qm.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra got=%h", out_mag);
                end else begin
                    em = qm.pop_front();
                    en = qn.pop_front();
                    exp_v = {em, en, em == 8'h00, 1'b0};
                    got = {out_mag, out_neg, out_zero, out_err};
                    if (got !== exp_v) begin
                        n_fail++;
                        $display("FAIL stream_beat got=%h exp=%h",
                                 got, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                qm.push_back((a >= b) ? a - b : b - a);
                qn.push_back(a < b);
                acc_n++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc_n != 10000 || qm.size() != 0) begin
            n_fail++;
            $display("FAIL stream_timeout got=%0d/%0d exp=10000/0",
                     acc_n, qm.size());
        end
    endtask

`ifdef SUB_DEC_STATS_EN
    task automatic test_stats();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_cout = 1'b0;
        in_diff = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        n_checks++;
        if (neg_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL stats_neg got=%h exp=ff", neg_count);
        end
        in_cout = 1'b1;
        in_diff = 8'h01;
        for (int i = 0; i < 65237; i++) begin
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (beat_count !== 16'h0001) begin
            n_fail++;
            $display("FAIL stats_beat got=%h exp=0001", beat_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_diff = 8'h00;
        in_cout = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_decode();
        test_backpressure();
        test_push_pop_one();
        test_reset_mid();
        test_random_stream();
`ifdef SUB_DEC_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
